axi_mem_initiator: RTL and testbench
====================================

Name: axi_mem_initiator

Overview:
AXI4 initiator (master) bridging a simple single-request memory-style command port onto a 64-bit AXI4 bus.
- Issues exactly one single-beat transaction at a time: INCR burst, len 0, size 3.
- Sits between simple on-chip requesters (boot loader, debug/test sequencer) and the AXI interconnect.
- Acts as the counterpart to the team's AXI register-slave blocks.

Parameters:
ID_WIDTH, 1, width of AXI ID fields
AXI_ID, 0, constant ID driven on AWID/ARID

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
i_req  in  1  command valid; sampled only in IDLE
i_we  in  1  1 = write, 0 = read
i_addr  in  32  byte address
i_be  in  8  write byte enables
i_wdata  in  64  write data
o_busy  out  1  high from command capture until o_ack
o_ack  out  1  one-cycle completion pulse
o_err  out  1  valid with o_ack; 1 = SLVERR/DECERR or rejected command
o_rdata  out  64  read data; valid with o_ack, held until next ack
o_awid/o_awaddr/o_awlen/o_awsize/o_awburst/o_awvalid  out  ID_WIDTH/32/8/3/2/1  AW channel
i_awready  in  1
o_wdata/o_wstrb/o_wlast/o_wvalid  out  64/8/1/1  W channel
i_wready  in  1
i_bid/i_bresp/i_bvalid  in  ID_WIDTH/2/1  B channel
o_bready  out  1
o_arid/o_araddr/o_arlen/o_arsize/o_arburst/o_arvalid  out  ID_WIDTH/32/8/3/2/1  AR channel
i_arready  in  1
i_rid/i_rdata/i_rresp/i_rlast/i_rvalid  in  ID_WIDTH/64/2/1/1  R channel
o_rready  out  1

Behaviour:
- Reset is one clock, synchronous, active-low (rst_n low at a clk edge).
  - After that edge: state = IDLE; all valid outputs, o_bready, o_rready, o_ack, o_err and o_busy = 0; o_rdata = 0.
  - Reset mid-transaction abandons the transaction at the next edge. The system must reset the slave side together with this block.
- Constant AXI fields: awlen = arlen = 0, awsize = arsize = 3, awburst = arburst = 2'b01, wlast = 1, awid = arid = AXI_ID.
- Command capture:
  - In IDLE, i_req = 1 registers addr/be/wdata/we and raises o_busy next cycle.
  - i_req is ignored while o_busy = 1 or o_ack = 1.
- Address/data outputs are registered and stable while the matching valid is high and ready is low (AXI rule). A valid never drops before its handshake.
- States and transitions:
  - IDLE: on i_req & i_we -> WADDR; on i_req & !i_we -> RADDR.
  - WADDR: awvalid and wvalid both asserted on entry. Each drops independently after its own handshake; aw_done/w_done flags track completion. Both handshakes may occur in the same cycle or in either order. When both are done -> WRESP.
  - WRESP: o_bready = 1. On i_bvalid -> ACK, with err = |i_bresp.
  - RADDR: arvalid = 1. On i_arready -> RDATA.
  - RDATA: o_rready = 1. On i_rvalid -> capture i_rdata into o_rdata, err = |i_rresp -> ACK. i_rlast is ignored because len = 0.
  - ACK: o_ack = 1 for exactly one cycle, o_busy drops -> IDLE. The earliest next capture is the cycle after ACK.
- Minimum latency, i_req to o_ack, with all readies tied high:
  - write: 4 cycles (capture, AW/W, B, ACK)
  - read: 4 cycles (capture, AR, R, ACK)
- i_bid and i_rid are not checked. Only one transaction is ever outstanding.

Optional Feature:
Macro: AXI_INITIATOR_ALIGN_CHECK_EN
- Defined: a command with i_addr[2:0] != 0 produces no bus activity. The block goes IDLE -> ACK with o_err = 1 and o_rdata unchanged.
- Not defined: address passed unmodified, and the slave handles alignment.

Decomposition:
- Shared package axi_init_pkg holds:
  - state enum (IDLE, WADDR, WRESP, RADDR, RDATA, ACK)
  - constants BURST_INCR = 2'b01, SIZE_64 = 3'd3, RESP_OKAY = 2'b00
- No sub-module; a single FSM file is natural.
- Optional sub-module axi_init_chan_hold for the valid/ready hold register, instantiated for AW, W and AR.

Test Plan:
1. Write 0x8000_0010, be 0xFF, data 0x1122334455667788, readies high, bresp 0 -> one AW and one W beat carrying exactly those values, o_ack at cycle 4, o_err = 0.
2. Read 0x8000_0008, slave returns rdata 0xDEADBEEF_CAFEF00D with rresp 0 -> o_rdata equals that value on the o_ack cycle and holds until the next ack.
3. Write with awready delayed 3 cycles and wready delayed 1 cycle, then the reverse order -> awaddr and wdata stay stable while waiting, each valid drops exactly once, a single B is accepted, then o_ack.
4. Read with rresp 2'b10, then write with bresp 2'b11 -> o_err = 1 on both acks.
5. rst_n low for 1 cycle while in WRESP -> all valids, readies, o_ack and o_busy are 0 on the next edge; a new i_req afterwards completes normally.
6. With AXI_INITIATOR_ALIGN_CHECK_EN, read 0x8000_0004 -> no arvalid ever asserted, o_ack with o_err = 1 two cycles after i_req.

Source files
------------

// File: rtl/axi_init_pkg.sv
// Shared types and AXI field constants for the single-beat AXI4 memory initiator.
package axi_init_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWresp,
    StRaddr,
    StRdata,
    StAck
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_64    = 3'd3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/axi_mem_initiator.sv
// AXI4 initiator: one 64-bit single-beat INCR transaction per captured command.
// Define AXI_INITIATOR_ALIGN_CHECK_EN to reject commands that are not 8-byte aligned.
module axi_mem_initiator
  import axi_init_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 1,
  parameter int unsigned AXI_ID   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [31:0]         i_addr,
  input  logic [7:0]          i_be,
  input  logic [63:0]         i_wdata,
  output logic                o_busy,
  output logic                o_ack,
  output logic                o_err,
  output logic [63:0]         o_rdata,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [31:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [2:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [7:0]  be_q;
  logic [63:0] wdata_q;
  logic        awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic        aw_done_q, w_done_q;
  logic        busy_q, ack_q, err_q;
  logic [63:0] rdata_q;

  logic aw_hs, w_hs, misaligned;

  assign aw_hs = awvalid_q & i_awready;
  assign w_hs  = wvalid_q & i_wready;

`ifdef AXI_INITIATOR_ALIGN_CHECK_EN
  assign misaligned = (i_addr[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  // IDs are not checked and len is always 0, so rlast carries no information.
  logic unused_inputs;
  assign unused_inputs = ^{i_bid, i_rid, i_rlast};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req) begin
            addr_q  <= i_addr;
            be_q    <= i_be;
            wdata_q <= i_wdata;
            if (misaligned) begin
              state_q <= StAck;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else if (i_we) begin
              state_q   <= StWaddr;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= StRaddr;
              arvalid_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        StWaddr: begin
          // AW and W complete independently, in either order or together.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            state_q  <= StWresp;
            bready_q <= 1'b1;
          end
        end
        StWresp: begin
          if (i_bvalid) begin
            bready_q <= 1'b0;
            err_q    <= (i_bresp != RESP_OKAY);
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StAck;
          end
        end
        StRaddr: begin
          if (i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (i_rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= i_rdata;
            err_q    <= (i_rresp != RESP_OKAY);
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StAck;
          end
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_ack     = ack_q;
  assign o_err     = err_q;
  assign o_rdata   = rdata_q;

  assign o_awid    = ID_WIDTH'(AXI_ID);
  assign o_awaddr  = addr_q;
  assign o_awlen   = LEN_SINGLE;
  assign o_awsize  = SIZE_64;
  assign o_awburst = BURST_INCR;
  assign o_awvalid = awvalid_q;

  assign o_wdata   = wdata_q;
  assign o_wstrb   = be_q;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = wvalid_q;

  assign o_bready  = bready_q;

  assign o_arid    = ID_WIDTH'(AXI_ID);
  assign o_araddr  = addr_q;
  assign o_arlen   = LEN_SINGLE;
  assign o_arsize  = SIZE_64;
  assign o_arburst = BURST_INCR;
  assign o_arvalid = arvalid_q;

  assign o_rready  = rready_q;

endmodule

// File: tb/tb_axi_mem_initiator.sv
// Scoreboard bench for axi_mem_initiator: directed commands against a small AXI slave model.
module tb_axi_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_addr = '0;
  logic [7:0]  i_be = '0;
  logic [63:0] i_wdata = '0;
  logic        o_busy, o_ack, o_err;
  logic [63:0] o_rdata;
  logic [0:0]  o_awid, o_arid;
  logic [31:0] o_awaddr, o_araddr;
  logic [7:0]  o_awlen, o_arlen;
  logic [2:0]  o_awsize, o_arsize;
  logic [1:0]  o_awburst, o_arburst;
  logic        o_awvalid, o_arvalid, o_wvalid, o_wlast, o_bready, o_rready;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic        i_awready = 1'b0, i_wready = 1'b0, i_arready = 1'b0;
  logic [0:0]  i_bid = '0, i_rid = '0;
  logic [1:0]  i_bresp = '0, i_rresp = '0;
  logic        i_bvalid = 1'b0, i_rvalid = 1'b0, i_rlast = 1'b0;
  logic [63:0] i_rdata = '0;

  axi_mem_initiator #(.ID_WIDTH(1), .AXI_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_be(i_be), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } ack_t;

  int n_vec = 0;
  int n_fail = 0;

  logic [31:0] exp_aw_q[$];
  logic [71:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];
  ack_t        exp_ack_q[$];
  logic [63:0] model_rdata = '0;

  // Slave configuration, set by the stimulus before each command.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
  logic [63:0] cfg_rdata = '0;
  bit          b_hold = 1'b0;

  // Slave/monitor state.
  int          aw_cnt, w_cnt, ar_cnt;
  bit          aw_got, w_got, ar_got, b_pend, r_pend;
  bit          aw_wait, w_wait, ar_wait;
  logic [31:0] aw_hold, ar_hold;
  logic [71:0] w_hold;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

  function automatic void check(input string name, input logic [127:0] got,
                                input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endfunction

  // Slave responses and scoreboard monitor, all evaluated on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      i_awready = 0; i_wready = 0; i_arready = 0;
      i_bvalid = 0; i_rvalid = 0; i_bresp = '0; i_rresp = '0; i_rdata = '0; i_rlast = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
    end else begin
      if (o_ack) begin
        if (exp_ack_q.size() == 0) unexpected("ack");
        else begin
          ack_t e;
          e = exp_ack_q.pop_front();
          check("ack_err", o_err, e.err);
          check("ack_rdata", o_rdata, e.rdata);
        end
      end
      if (aw_wait) check("aw_stable", {o_awvalid, o_awaddr}, {1'b1, aw_hold});
      if (w_wait) check("w_stable", {o_wvalid, o_wstrb, o_wdata}, {1'b1, w_hold});
      if (ar_wait) check("ar_stable", {o_arvalid, o_araddr}, {1'b1, ar_hold});
      aw_wait = 0; w_wait = 0; ar_wait = 0;

      // Responses only follow address handshakes seen on an earlier edge.
      if (b_pend) begin i_bvalid = 0; b_pend = 0; end
      if (!i_bvalid && aw_got && w_got && !b_hold) begin
        i_bvalid = 1; i_bresp = cfg_bresp; aw_got = 0; w_got = 0;
      end
      if (i_bvalid && o_bready) begin n_b++; b_pend = 1; end

      if (r_pend) begin i_rvalid = 0; r_pend = 0; end
      if (!i_rvalid && ar_got) begin
        i_rvalid = 1; i_rdata = cfg_rdata; i_rresp = cfg_rresp; i_rlast = 1; ar_got = 0;
      end
      if (i_rvalid && o_rready) begin n_r++; r_pend = 1; end

      if (!o_awvalid) begin i_awready = 0; aw_cnt = 0; end
      else begin
        if (!i_awready) begin i_awready = (aw_cnt >= aw_delay); aw_cnt++; end
        if (i_awready) begin
          n_aw++; aw_got = 1;
          if (exp_aw_q.size() == 0) unexpected("aw_beat");
          else check("aw_beat", {o_awid, o_awlen, o_awsize, o_awburst, o_awaddr},
                     {1'b0, 8'd0, 3'd3, 2'b01, exp_aw_q.pop_front()});
        end else begin aw_wait = 1; aw_hold = o_awaddr; end
      end

      if (!o_wvalid) begin i_wready = 0; w_cnt = 0; end
      else begin
        if (!i_wready) begin i_wready = (w_cnt >= w_delay); w_cnt++; end
        if (i_wready) begin
          n_w++; w_got = 1;
          if (exp_w_q.size() == 0) unexpected("w_beat");
          else begin
            logic [71:0] ew;
            ew = exp_w_q.pop_front();
            check("w_beat", {o_wlast, o_wstrb, o_wdata}, {1'b1, ew[7:0], ew[71:8]});
          end
        end else begin w_wait = 1; w_hold = {o_wstrb, o_wdata}; end
      end

      if (!o_arvalid) begin i_arready = 0; ar_cnt = 0; end
      else begin
        if (!i_arready) begin i_arready = (ar_cnt >= ar_delay); ar_cnt++; end
        if (i_arready) begin
          n_ar++; ar_got = 1;
          if (exp_ar_q.size() == 0) unexpected("ar_beat");
          else check("ar_beat", {o_arid, o_arlen, o_arsize, o_arburst, o_araddr},
                     {1'b0, 8'd0, 3'd3, 2'b01, exp_ar_q.pop_front()});
        end else begin ar_wait = 1; ar_hold = o_araddr; end
      end
    end
  end

  // Issue one command, push its expectations, and wait (bounded) for the ack.
  task automatic run_cmd(input bit we, input logic [31:0] addr, input logic [7:0] be,
                         input logic [63:0] data, input bit exp_err, input int exp_cycle,
                         input bit bus);
    int   lat;
    int   aw0, w0, b0, ar0, r0;
    ack_t e;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    if (bus && we) begin
      exp_aw_q.push_back(addr);
      exp_w_q.push_back({data, be});
    end else if (bus) begin
      exp_ar_q.push_back(addr);
      model_rdata = cfg_rdata;
    end
    e.err = exp_err;
    e.rdata = model_rdata;
    exp_ack_q.push_back(e);
    @(negedge clk);
    i_req = 1; i_we = we; i_addr = addr; i_be = be; i_wdata = data;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        i_req = 0;
        check("busy_after_capture", o_busy, bus);
      end
      lat++;
    end while (!o_ack && lat < 50);
    if (!o_ack) unexpected("ack_timeout");
    else if (exp_cycle > 0) check("ack_cycle", lat + 1, exp_cycle);
    check("beat_counts", {8'(n_aw - aw0), 8'(n_w - w0), 8'(n_b - b0), 8'(n_ar - ar0),
          8'(n_r - r0)}, {7'd0, bus && we, 7'd0, bus && we, 7'd0, bus && we,
          7'd0, bus && !we, 7'd0, bus && !we});
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("reset_state", {o_busy, o_ack, o_err, o_awvalid, o_wvalid, o_arvalid, o_bready,
          o_rready, o_rdata}, '0);

    // Basic write then read, readies immediate.
    run_cmd(1, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 0, 4, 1);
    cfg_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    run_cmd(0, 32'h8000_0008, 8'h00, 64'h0, 0, 4, 1);
    repeat (2) @(negedge clk);
    check("rdata_hold", o_rdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Back-pressure on AW and W, both orders.
    aw_delay = 3; w_delay = 1;
    run_cmd(1, 32'h8000_0020, 8'h0F, 64'hAAAA_5555_AAAA_5555, 0, 0, 1);
    aw_delay = 1; w_delay = 3;
    run_cmd(1, 32'h8000_0028, 8'hF0, 64'h0F0F_F0F0_1234_5678, 0, 0, 1);
    aw_delay = 0; w_delay = 0;

    // Error responses.
    cfg_rresp = 2'b10; cfg_rdata = 64'h0123_4567_89AB_CDEF;
    run_cmd(0, 32'h8000_0100, 8'h00, 64'h0, 1, 4, 1);
    cfg_rresp = 2'b00;
    cfg_bresp = 2'b11;
    run_cmd(1, 32'h8000_0108, 8'h3C, 64'hFEDC_BA98_7654_3210, 1, 4, 1);
    cfg_bresp = 2'b00;

    // Reset while waiting in the write-response state.
    b_hold = 1;
    exp_aw_q.push_back(32'h8000_0200);
    exp_w_q.push_back({64'h5A5A_5A5A_5A5A_5A5A, 8'hFF});
    @(negedge clk);
    i_req = 1; i_we = 1; i_addr = 32'h8000_0200; i_be = 8'hFF; i_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
    @(negedge clk);
    i_req = 0;
    guard = 0;
    while (!o_bready && guard < 20) begin @(negedge clk); guard++; end
    check("reached_wresp", o_bready, 1'b1);
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    check("mid_txn_reset", {o_busy, o_ack, o_err, o_awvalid, o_wvalid, o_arvalid, o_bready,
          o_rready, o_rdata}, '0);
    b_hold = 0;
    model_rdata = '0;
    exp_ack_q.delete();
    run_cmd(1, 32'h8000_0300, 8'h81, 64'hC001_D00D_0000_0001, 0, 4, 1);
    cfg_rdata = 64'h7777_8888_9999_AAAA;
    run_cmd(0, 32'h8000_0308, 8'h00, 64'h0, 0, 4, 1);

`ifdef AXI_INITIATOR_ALIGN_CHECK_EN
    run_cmd(0, 32'h8000_0004, 8'h00, 64'h0, 1, 2, 0);
    run_cmd(1, 32'h8000_0033, 8'hFF, 64'h1, 1, 2, 0);
`else
    cfg_rdata = 64'h0BAD_A11C_0000_0004;
    run_cmd(0, 32'h8000_0004, 8'h00, 64'h0, 0, 4, 1);
`endif

    repeat (3) @(negedge clk);
    check("queues_drained", {8'(exp_aw_q.size()), 8'(exp_w_q.size()), 8'(exp_ar_q.size()),
          8'(exp_ack_q.size())}, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
